// File: rtl/rename_reg_file_pkg.sv
// Shared defaults for the rename register file and its helpers.
package rename_reg_file_pkg;
    localparam int NUM_REGS_D = 32;
    localparam int REG_BIT_D  = $clog2(NUM_REGS_D);
    localparam int ROB_BIT_D  = 4;
    localparam int DAT_W      = 32;
    localparam int OP_W_D     = 6;

    // Tag value reported whenever a register is not waiting on the ROB
    localparam logic [ROB_BIT_D-1:0] ZERO_TAG = '0;
endpackage

// File: rtl/rename_reg_file_if.sv
// Issue, commit and operand-packet signals of the rename register file.
interface rename_reg_file_if #(
    parameter int REG_BIT = rename_reg_file_pkg::REG_BIT_D,
    parameter int XLEN    = rename_reg_file_pkg::DAT_W,
    parameter int ROB_BIT = rename_reg_file_pkg::ROB_BIT_D,
    parameter int OP_W    = rename_reg_file_pkg::OP_W_D
) ();
    // issue side
    logic               is_en_i;
    logic               is_rdy_o;
    logic [REG_BIT-1:0] is_rd_i;
    logic [REG_BIT-1:0] is_rs1_i;
    logic [REG_BIT-1:0] is_rs2_i;
    logic [OP_W-1:0]    is_op_i;
    logic [XLEN-1:0]    is_imm_i;
    logic [ROB_BIT-1:0] is_rob_qd_i;
    // commit side
    logic               rob_en_i;
    logic [REG_BIT-1:0] rob_rd_i;
    logic [ROB_BIT-1:0] rob_q_i;
    logic [XLEN-1:0]    rob_v_i;
    // operand packet to the ROB
    logic               rob_en_o;
    logic               rob_rdy_i;
    logic [XLEN-1:0]    rob_vj_o;
    logic [XLEN-1:0]    rob_vk_o;
    logic               rob_bj_o;
    logic               rob_bk_o;
    logic [ROB_BIT-1:0] rob_qj_o;
    logic [ROB_BIT-1:0] rob_qk_o;
    logic [ROB_BIT-1:0] rob_qd_o;
    logic [OP_W-1:0]    rob_op_o;
    logic [XLEN-1:0]    rob_imm_o;

    modport slave (
        input  is_en_i, is_rd_i, is_rs1_i, is_rs2_i, is_op_i, is_imm_i, is_rob_qd_i,
        input  rob_en_i, rob_rd_i, rob_q_i, rob_v_i, rob_rdy_i,
        output is_rdy_o, rob_en_o, rob_vj_o, rob_vk_o, rob_bj_o, rob_bk_o,
        output rob_qj_o, rob_qk_o, rob_qd_o, rob_op_o, rob_imm_o
    );

    modport master (
        output is_en_i, is_rd_i, is_rs1_i, is_rs2_i, is_op_i, is_imm_i, is_rob_qd_i,
        output rob_en_i, rob_rd_i, rob_q_i, rob_v_i, rob_rdy_i,
        input  is_rdy_o, rob_en_o, rob_vj_o, rob_vk_o, rob_bj_o, rob_bk_o,
        input  rob_qj_o, rob_qk_o, rob_qd_o, rob_op_o, rob_imm_o
    );
endinterface

// File: rtl/rename_reg_file_src_read.sv
// One source operand lookup: x0 check, commit forwarding, busy/tag select.
module rf_src_read
    import rename_reg_file_pkg::*;
#(
    parameter int REG_BIT = REG_BIT_D,
    parameter int XLEN    = DAT_W,
    parameter int ROB_BIT = ROB_BIT_D
) (
    input  logic [REG_BIT-1:0] rs,
    input  logic               cm_en,
    input  logic [REG_BIT-1:0] cm_rd,
    input  logic [ROB_BIT-1:0] cm_q,
    input  logic [XLEN-1:0]    cm_v,
    input  logic [XLEN-1:0]    st_val,
    input  logic               st_busy,
    input  logic [ROB_BIT-1:0] st_tag,
    output logic [XLEN-1:0]    val,
    output logic               busy,
    output logic [ROB_BIT-1:0] tag
);
    // Stored status unless x0 or a same-cycle commit to this register
    always_comb begin
        val  = st_val;
        busy = st_busy;
        tag  = st_tag;
        if (rs == '0) begin
            val  = '0;
            busy = 1'b0;
            tag  = ROB_BIT'(ZERO_TAG);
        end else if (cm_en && (cm_rd == rs)) begin
            val = cm_v;
            // only the youngest producer releases the rename
            if (st_busy && (st_tag == cm_q)) begin
                busy = 1'b0;
                tag  = ROB_BIT'(ZERO_TAG);
            end
        end
    end
endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename status and a registered operand packet.
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int XLEN     = DAT_W,
    parameter int ROB_BIT  = ROB_BIT_D,
    parameter int OP_W     = OP_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush_i,
    rename_reg_file_if.slave rf
);
    localparam int REG_BIT = $clog2(NUM_REGS);
    localparam int NSRC    = 2;

    logic [NUM_REGS-1:0][XLEN-1:0]    regs;
    logic [NUM_REGS-1:0]              busy;
    logic [NUM_REGS-1:0][ROB_BIT-1:0] tag;

    logic commit, accept, rename, is_rdy;

    logic [NSRC-1:0][REG_BIT-1:0] src_rs;
    logic [NSRC-1:0][XLEN-1:0]    src_val;
    logic [NSRC-1:0]              src_busy;
    logic [NSRC-1:0][ROB_BIT-1:0] src_tag;

    assign is_rdy      = !rf.rob_en_o || rf.rob_rdy_i;
    assign rf.is_rdy_o = is_rdy;
    assign commit      = en && rf.rob_en_i && (rf.rob_rd_i != '0);
    assign accept      = en && rf.is_en_i && is_rdy && !flush_i;
    assign rename      = accept && (rf.is_rd_i != '0);
    assign src_rs[0]   = rf.is_rs1_i;
    assign src_rs[1]   = rf.is_rs2_i;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        rf_src_read #(
            .REG_BIT(REG_BIT),
            .XLEN   (XLEN),
            .ROB_BIT(ROB_BIT)
        ) u_src (
            .rs     (src_rs[s]),
            .cm_en  (commit),
            .cm_rd  (rf.rob_rd_i),
            .cm_q   (rf.rob_q_i),
            .cm_v   (rf.rob_v_i),
            .st_val (regs[src_rs[s]]),
            .st_busy(busy[src_rs[s]]),
            .st_tag (tag[src_rs[s]]),
            .val    (src_val[s]),
            .busy   (src_busy[s]),
            .tag    (src_tag[s])
        );
    end

    // Storage update: commit write/clear, then rename, then flush (later wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
            busy <= '0;
            tag  <= '0;
        end else if (en) begin
            if (commit) begin
                regs[rf.rob_rd_i] <= rf.rob_v_i;
                if (busy[rf.rob_rd_i] && (tag[rf.rob_rd_i] == rf.rob_q_i)) begin
                    busy[rf.rob_rd_i] <= 1'b0;
                    tag[rf.rob_rd_i]  <= '0;
                end
            end
            if (rename) begin
                busy[rf.is_rd_i] <= 1'b1;
                tag[rf.is_rd_i]  <= rf.is_rob_qd_i;
            end
            if (flush_i) begin
                busy <= '0;
                tag  <= '0;
            end
        end
    end

    // Operand packet register: load on accept, drop valid once consumed or flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            rf.rob_en_o  <= 1'b0;
            rf.rob_vj_o  <= '0;
            rf.rob_vk_o  <= '0;
            rf.rob_bj_o  <= 1'b0;
            rf.rob_bk_o  <= 1'b0;
            rf.rob_qj_o  <= '0;
            rf.rob_qk_o  <= '0;
            rf.rob_qd_o  <= '0;
            rf.rob_op_o  <= '0;
            rf.rob_imm_o <= '0;
        end else if (en) begin
            if (flush_i) begin
                rf.rob_en_o <= 1'b0;
            end else if (accept) begin
                rf.rob_en_o  <= 1'b1;
                rf.rob_vj_o  <= src_val[0];
                rf.rob_vk_o  <= src_val[1];
                rf.rob_bj_o  <= src_busy[0];
                rf.rob_bk_o  <= src_busy[1];
                rf.rob_qj_o  <= src_tag[0];
                rf.rob_qk_o  <= src_tag[1];
                rf.rob_qd_o  <= rf.is_rob_qd_i;
                rf.rob_op_o  <= rf.is_op_i;
                rf.rob_imm_o <= rf.is_imm_i;
            end else if (rf.rob_rdy_i) begin
                rf.rob_en_o <= 1'b0;
            end
        end
    end
endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Parametrised architectural register file with per-register rename status (busy bit plus ROB tag), sitting between instruction issue and the ROB. On issue, it reads two source operands, renames the destination to a ROB entry, and presents a registered operand packet to the ROB through a valid/ready handshake. On commit, it writes the value and clears the rename only if the tag still matches. It adds an explicit busy bit, same-cycle commit-to-issue forwarding, output backpressure and a global rename flush for mispredict recovery.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count (power of two, ≥2); register 0 hardwired to zero
- XLEN, 32, data width
- ROB_BIT, 4, ROB tag width
- OP_W, 6, opcode width passed through

Ports (REG_BIT = clog2(NUM_REGS)):
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable; low freezes all state and outputs
- flush_i  in  1  mispredict; drop all renames and the pending output
- is_en_i  in  1  issue request
- is_rdy_o  out  1  issue can be accepted this cycle
- is_rd_i / is_rs1_i / is_rs2_i  in  REG_BIT  destination and sources
- is_op_i  in  OP_W; is_imm_i  in  XLEN  pass-through
- is_rob_qd_i  in  ROB_BIT  ROB entry allocated to this instruction
- rob_en_i  in  1  commit write
- rob_rd_i  in  REG_BIT; rob_q_i  in  ROB_BIT; rob_v_i  in  XLEN  committing register, tag, value
- rob_en_o  out  1  operand packet valid
- rob_rdy_i  in  1  ROB accepts the packet
- rob_vj_o / rob_vk_o  out  XLEN  source values
- rob_bj_o / rob_bk_o  out  1  source still pending (busy)
- rob_qj_o / rob_qk_o  out  ROB_BIT  producing tag; zero when not busy
- rob_qd_o  out  ROB_BIT; rob_op_o  out  OP_W; rob_imm_o  out  XLEN  pass-through

## Operation
- Reset: all regs, tags and busy bits zero; all outputs zero; is_rdy_o = 1.
- is_rdy_o = !rob_en_o || rob_rdy_i (combinational). Issue is accepted when en && is_en_i && is_rdy_o && !flush_i.
- Commit (en && rob_en_i && rob_rd_i != 0): regs[rd] <= rob_v_i; if busy[rd] && tag[rd] == rob_q_i, busy[rd] <= 0 and tag[rd] <= 0.
- Source read per rs, evaluated on pre-edge state:
  - If rs == 0: value 0, busy 0, tag 0.
  - If a commit writes rs this cycle: value = rob_v_i; busy/tag cleared if the commit tag matches, else the stored busy/tag.
  - Otherwise: stored value, busy and tag.
- Rename on accept with rd != 0: busy[rd] <= 1, tag[rd] <= is_rob_qd_i. Rename wins over a same-cycle commit clear on the same rd. Sources equal to rd see the old status.
- Output: on accept, load the packet and set rob_en_o = 1. Otherwise, if rob_rdy_i, clear rob_en_o; data is held.
- Flush: all busy and tag bits cleared, and rob_en_o cleared. Issue is ignored. A same-cycle commit still writes its value; its tag clear is moot.
- With en low, nothing changes. Upstream must not assert commit or issue while en is low.

## Timing
- Issue to packet valid: 1 cycle. The packet is stable until the cycle after rob_rdy_i is sampled high.
- Commit to value visible: 0 cycles via forwarding, 1 cycle via storage.
- Full throughput is one issue per cycle while rob_rdy_i stays high.
- A rename is visible to the next cycle's issue.

## Structure
- Shared head package holds REG_BIT, ROB_BIT, DAT_W and OP_W defaults and the zero-tag constant.
- Sub-module rf_src_read covers one source: zero-register check, commit forwarding, busy/tag select. It is purely combinational and instantiated twice.
- Top level holds the storage arrays, rename/commit update and the output register.

## Test plan
- Reset, then issue rs1=1, rs2=2, rd=3, qd=5 → next cycle rob_en_o=1, vj=vk=0, bj=bk=0; then issue rs1=3 → bj=1, qj=5.
- Rename x3→tag 5, then commit rd=3, q=5, v=0xAB while issuing rs1=3 in the same cycle → vj=0xAB, bj=0; busy[3] cleared.
- Rename x3→5, then x3→7, then commit rd=3, q=5, v=0x11 → value stored, but a later read of x3 gives bj=1, qj=7.
- Issue rd=0 and rs1=0 with a commit to x0, v=0xFF → vj=0 and no rename.
- Hold rob_rdy_i=0 with a packet valid → is_rdy_o=0 and the packet is held; raise rob_rdy_i → is_rdy_o=1 in the same cycle, and a new issue replaces the packet.
- Rename x1..x4, then flush with issue and commit (rd=2, v=9) in the same cycle → rob_en_o=0, all busy bits 0, issue dropped, x2 reads 9.
